// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential N-bit ALU: op codes, FSM states, engine modes.
// ALU_SEQ_MUL_EN selects whether op 8 is the iterative multiplier or a PASS alias.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_LSR  = 4'd5,
        OP_LSL  = 4'd6,
        OP_MOD  = 4'd7,
`ifdef ALU_SEQ_MUL_EN
        OP_MUL  = 4'd8,
`else
        OP_PASS = 4'd8,
`endif
        OP_DIV  = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    localparam logic MODE_DIV = 1'b0;
    localparam logic MODE_MUL = 1'b1;

    // Ops that run on the bit-serial engine instead of completing at accept.
    function automatic logic is_iter(input logic [3:0] op);
        logic r;
        r = (op == OP_MOD) || (op == OP_DIV);
`ifdef ALU_SEQ_MUL_EN
        r = r || (op == OP_MUL);
`endif
        return r;
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Bit-serial unsigned engine: restoring divider and (with ALU_SEQ_MUL_EN) shift-add
// multiplier sharing one hi/lo register pair. Outputs expose the post-step values.
module alu_iter_muldiv
    import alu_seq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         mode,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         done,
    output logic [N-1:0] quo_lo,
    output logic [N-1:0] rem_hi,
    output logic         div0
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    logic [N-1:0]  hi_q, hi_d;
    logic [N-1:0]  lo_q, lo_d;
    logic [N-1:0]  b_q, b_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;

    logic [N-1:0]  hi_step, lo_step;
    logic [N:0]    rem_sh;
    logic [N+1:0]  diff;
    logic          unused_diff_bit;

`ifdef ALU_SEQ_MUL_EN
    logic          mode_q, mode_d;
    logic [N:0]    mac;
`else
    logic          unused_mode;
    assign unused_mode = mode;
`endif

    assign unused_diff_bit = diff[N];

    // One iteration of whichever algorithm is in flight.
    always_comb begin
        rem_sh  = {hi_q, lo_q[N-1]};
        diff    = {1'b0, rem_sh} - {2'b00, b_q};
        // A successful trial subtraction leaves a remainder below b, so N bits suffice.
        hi_step = diff[N+1] ? rem_sh[N-1:0] : diff[N-1:0];
        lo_step = {lo_q[N-2:0], ~diff[N+1]};
`ifdef ALU_SEQ_MUL_EN
        mac = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(N+1){1'b0}});
        if (mode_q == MODE_MUL) begin
            hi_step = mac[N:1];
            lo_step = {mac[0], lo_q[N-1:1]};
        end
`endif
    end

    assign done   = busy_q && (cnt_q == '0);
    assign quo_lo = lo_step;
    assign rem_hi = hi_step;
    assign div0   = (b_q == '0);

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        b_d    = b_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
`ifdef ALU_SEQ_MUL_EN
        mode_d = mode_q;
`endif
        if (start) begin
            hi_d   = '0;
            lo_d   = a;
            b_d    = b;
            cnt_d  = CW'(N - 1);
            busy_d = 1'b1;
`ifdef ALU_SEQ_MUL_EN
            mode_d = mode;
`endif
        end else if (busy_q) begin
            hi_d   = hi_step;
            lo_d   = lo_step;
            cnt_d  = done ? '0 : cnt_q - CW'(1);
            busy_d = ~done;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            mode_q <= MODE_DIV;
`endif
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            b_q    <= b_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
`ifdef ALU_SEQ_MUL_EN
            mode_q <= mode_d;
`endif
        end
    end

endmodule

// File: rtl/alu_seq_n_bits.sv
// Clocked N-bit ALU with valid/ready handshake, registered result and flags.
// ALU_SEQ_MUL_EN builds op 8 as an iterative multiplier; otherwise op 8 is PASS.
module alu_seq_n_bits
    import alu_seq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   control,
    output logic         out_valid,
    output logic [N-1:0] result,
    output logic [N-1:0] result_hi,
    output logic         v,
    output logic         c,
    output logic         n,
    output logic         z,
    output logic         div0
);

    localparam logic [N:0] N_LIM = (N + 1)'(N);

    alu_state_e   state_q, state_d;
    logic [3:0]   op_q, op_d;
    logic [N-1:0] result_q, result_d;
    logic [N-1:0] result_hi_q, result_hi_d;
    logic         v_q, v_d, c_q, c_d, n_q, n_d, z_q, z_d, div0_q, div0_d;

    logic         accept;
    logic         eng_start, eng_mode, eng_done, eng_div0;
    logic [N-1:0] eng_quo_lo, eng_rem_hi;

    logic [N-1:0] b_eff;
    logic [N:0]   sum;
    logic         shift_big;
    logic [N-1:0] sc_res;
    logic         sc_c, sc_v;

    logic [N-1:0] it_res, it_hi;
    logic         it_c, it_v, it_div0;

    assign accept    = in_valid && (state_q == IDLE);
    assign eng_start = accept && is_iter(control);
`ifdef ALU_SEQ_MUL_EN
    assign eng_mode  = (control == OP_MUL) ? MODE_MUL : MODE_DIV;
`else
    assign eng_mode  = MODE_DIV;
`endif

    alu_iter_muldiv #(.N(N)) u_engine (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (eng_start),
        .mode   (eng_mode),
        .a      (a),
        .b      (b),
        .done   (eng_done),
        .quo_lo (eng_quo_lo),
        .rem_hi (eng_rem_hi),
        .div0   (eng_div0)
    );

    // Single-cycle datapath; SUB reuses the adder as a + ~b + 1.
    always_comb begin
        b_eff     = control[0] ? ~b : b;
        sum       = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, control[0]};
        shift_big = ({1'b0, b} >= N_LIM);
        sc_res    = a;
        sc_c      = 1'b0;
        sc_v      = 1'b0;
        case (control)
            OP_ADD, OP_SUB: begin
                sc_res = sum[N-1:0];
                sc_c   = sum[N];
                sc_v   = (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]);
            end
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_XOR:  sc_res = a ^ b;
            OP_LSR:  sc_res = shift_big ? '0 : (a >> b);
            OP_LSL:  sc_res = shift_big ? '0 : (a << b);
            default: sc_res = a;
        endcase
    end

    // Completion values for the engine ops, selected by the captured op.
    always_comb begin
        it_res  = (op_q == OP_MOD) ? eng_rem_hi : eng_quo_lo;
        it_hi   = '0;
        it_c    = 1'b0;
        it_v    = eng_div0;
        it_div0 = eng_div0;
`ifdef ALU_SEQ_MUL_EN
        if (op_q == OP_MUL) begin
            it_hi   = eng_rem_hi;
            it_c    = |eng_rem_hi;
            it_v    = |eng_rem_hi;
            it_div0 = 1'b0;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        v_d         = v_q;
        c_d         = c_q;
        n_d         = n_q;
        z_d         = z_q;
        div0_d      = div0_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d = control;
                    if (is_iter(control)) begin
                        state_d = EXEC;
                    end else begin
                        state_d     = DONE;
                        result_d    = sc_res;
                        result_hi_d = '0;
                        v_d         = sc_v;
                        c_d         = sc_c;
                        n_d         = sc_res[N-1];
                        z_d         = (sc_res == '0);
                        div0_d      = 1'b0;
                    end
                end
            end
            EXEC: begin
                if (eng_done) begin
                    state_d     = DONE;
                    result_d    = it_res;
                    result_hi_d = it_hi;
                    v_d         = it_v;
                    c_d         = it_c;
                    n_d         = it_res[N-1];
                    z_d         = (it_res == '0);
                    div0_d      = it_div0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            v_q         <= 1'b0;
            c_q         <= 1'b0;
            n_q         <= 1'b0;
            z_q         <= 1'b0;
            div0_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            v_q         <= v_d;
            c_q         <= c_d;
            n_q         <= n_d;
            z_q         <= z_d;
            div0_q      <= div0_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign v         = v_q;
    assign c         = c_q;
    assign n         = n_q;
    assign z         = z_q;
    assign div0      = div0_q;

endmodule

// File: tb/tb_alu_seq_n_bits.sv
// Directed bench for alu_seq_n_bits at N=4; follows ALU_SEQ_MUL_EN for the op 8 vector.
module tb_alu_seq_n_bits;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a, b;
    logic [3:0]   control;
    logic         out_valid;
    logic [N-1:0] result, result_hi;
    logic         v, c, n, z, div0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_seq_n_bits #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .control   (control),
        .out_valid (out_valid),
        .result    (result),
        .result_hi (result_hi),
        .v         (v),
        .c         (c),
        .n         (n),
        .z         (z),
        .div0      (div0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".in_ready"},  32'(in_ready),  32'd1);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".result"},    32'(result),    32'd0);
        check({tag, ".result_hi"}, 32'(result_hi), 32'd0);
        check({tag, ".vcnz"},      32'({v, c, n, z}), 32'd0);
        check({tag, ".div0"},      32'(div0),      32'd0);
    endtask

    // Present one op, keep in_valid high with junk operands while busy (must be
    // ignored), then check latency, ready behaviour, result and flags.
    task automatic do_op(input string tag, input logic [3:0] op,
                         input logic [N-1:0] ai, input logic [N-1:0] bi,
                         input logic [N-1:0] er, input logic [N-1:0] eh,
                         input logic ev, input logic ec, input logic en,
                         input logic ez, input logic ed, input int elat);
        int lat;
        @(negedge clk);
        check({tag, ".rdy_pre"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a        = ai;
        b        = bi;
        control  = op;
        @(negedge clk);
        a       = ~ai;
        b       = ~bi;
        control = op ^ 4'h3;
        lat     = 1;
        while (!out_valid && lat < 40) begin
            check({tag, ".rdy_busy"}, 32'(in_ready), 32'd0);
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        $display("op %s ctl=%0d a=%h b=%h -> res=%h hi=%h vcnz=%b div0=%b lat=%0d",
                 tag, op, ai, bi, result, result_hi, {v, c, n, z}, div0, lat);
        check({tag, ".lat"},       32'(lat),       32'(elat));
        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        check({tag, ".rdy_done"},  32'(in_ready),  32'd0);
        check({tag, ".result"},    32'(result),    32'(er));
        check({tag, ".result_hi"}, 32'(result_hi), 32'(eh));
        check({tag, ".v"},         32'(v),         32'(ev));
        check({tag, ".c"},         32'(c),         32'(ec));
        check({tag, ".n"},         32'(n),         32'(en));
        check({tag, ".z"},         32'(z),         32'(ez));
        check({tag, ".div0"},      32'(div0),      32'(ed));
        @(negedge clk);
        check({tag, ".pulse"},     32'(out_valid), 32'd0);
        check({tag, ".rdy_post"},  32'(in_ready),  32'd1);
        check({tag, ".hold"},      32'(result),    32'(er));
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        control  = '0;
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        //     tag        op     a     b     res   hi    v  c  n  z  d0 lat
        do_op("add",      4'd0, 4'h7, 4'h9, 4'h0, 4'h0, 0, 1, 0, 1, 0, 1);
        do_op("sub_neg",  4'd1, 4'h3, 4'h5, 4'hE, 4'h0, 0, 0, 1, 0, 0, 1);
        do_op("sub_ovf",  4'd1, 4'h8, 4'h1, 4'h7, 4'h0, 1, 1, 0, 0, 0, 1);
        do_op("and",      4'd2, 4'hC, 4'hA, 4'h8, 4'h0, 0, 0, 1, 0, 0, 1);
        do_op("or",       4'd3, 4'h5, 4'h2, 4'h7, 4'h0, 0, 0, 0, 0, 0, 1);
        do_op("xor",      4'd4, 4'hF, 4'hF, 4'h0, 4'h0, 0, 0, 0, 1, 0, 1);
        do_op("lsr",      4'd5, 4'hC, 4'h2, 4'h3, 4'h0, 0, 0, 0, 0, 0, 1);
        do_op("lsr_big",  4'd5, 4'hC, 4'h4, 4'h0, 4'h0, 0, 0, 0, 1, 0, 1);
        do_op("lsl",      4'd6, 4'h3, 4'h1, 4'h6, 4'h0, 0, 0, 0, 0, 0, 1);
        do_op("div",      4'd9, 4'hD, 4'h4, 4'h3, 4'h0, 0, 0, 0, 0, 0, 5);
        do_op("mod",      4'd7, 4'hD, 4'h4, 4'h1, 4'h0, 0, 0, 0, 0, 0, 5);
        do_op("div0",     4'd9, 4'h9, 4'h0, 4'hF, 4'h0, 1, 0, 1, 0, 1, 5);
        do_op("mod0",     4'd7, 4'h9, 4'h0, 4'h9, 4'h0, 1, 0, 1, 0, 1, 5);
`ifdef ALU_SEQ_MUL_EN
        do_op("mul",      4'd8, 4'h7, 4'h6, 4'hA, 4'h2, 1, 1, 1, 0, 0, 5);
`else
        do_op("mul_pass", 4'd8, 4'h7, 4'h6, 4'h7, 4'h0, 0, 0, 0, 0, 0, 1);
`endif
        do_op("pass",     4'd12, 4'h9, 4'h3, 4'h9, 4'h0, 0, 0, 1, 0, 0, 1);

        // Reset two cycles into a DIV: everything clears at once, no pulse follows.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 4'hD;
        b        = 4'h4;
        control  = 4'd9;
        @(negedge clk);
        in_valid = 1'b0;
        check("rst_mid.busy", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_mid.no_valid", 32'(out_valid), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst_post.no_valid", 32'(out_valid), 32'd0);
        end
        do_op("lsl_big",  4'd6, 4'h1, 4'h5, 4'h0, 4'h0, 0, 0, 0, 1, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq_n_bits.md
# alu_seq_n_bits

Parametrised, clocked successor to the lab's combinational N-bit ALU. It keeps the 4-bit operation encoding (add, sub, and, or, xor, shifts, mod, div) and adds an iterative unsigned multiplier and divider, registered results and flags, and a valid/ready handshake. The block sits between the operand/operation selection front end (switches, button-driven op counter) and the 7-segment display path. Only one operation is in flight at a time.

## Interface
- N, default 4: operand and result width, minimum 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and op are presented.
- in_ready  out  1  block can accept an operation. Equals 1 only in the IDLE state.
- a  in  N  operand A, unsigned.
- b  in  N  operand B, unsigned.
- control  in  4  op code: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 LSR, 6 LSL, 7 MOD, 8 MUL, 9 DIV, 10–15 PASS (result = a).
- out_valid  out  1  one-cycle pulse while result and flags are new.
- result  out  N  result (low half for MUL).
- result_hi  out  N  high half of the MUL product, 0 for every other op.
- v, c, n, z  out  1 each  overflow, carry, negative, zero flags.
- div0  out  1  last DIV/MOD had b == 0.
- One clock, clk. Reset rst_n is asynchronous and active-low.

## Operation
- State machine: IDLE, EXEC, DONE. The accept edge (E0) is a rising clk edge with in_valid & in_ready.
- Operands and op are captured at E0. Later changes on a, b and control have no effect until the next accept.
- Single-cycle ops (0–6, 10–15): result and flags are registered at E0, then IDLE→DONE.
- Iterative ops (7, 8, 9): IDLE→EXEC at E0, with the iteration counter loaded to N-1.
  - The engine processes one bit per cycle.
  - EXEC→DONE at the edge where the counter is 0, after N EXEC edges. Result and flags are registered on that edge.
- DONE→IDLE unconditionally on the next edge. out_valid = (state == DONE).
- result, result_hi, flags and div0 hold their values until the next DONE.
- ADD/SUB are computed as a + (b or ~b) + control[0], in N+1 bits.
  - c = bit N. For SUB, c = 1 means no borrow.
  - v = two's-complement overflow of the N-bit result.
- LSR/LSL: when b ≥ N the result is 0.
- MUL: unsigned shift-add. The 2N-bit product is split as {result_hi, result}. c = v = (result_hi != 0).
- DIV/MOD: unsigned restoring division. DIV returns the quotient, MOD returns the remainder.
  - When b == 0: quotient is all ones, remainder is a, div0 = 1 and v = 1. The op still takes the full N EXEC cycles.
- Flags for every op: z = (result == 0), n = result[N-1].
  - c and v are 0 except for ADD, SUB and MUL, and v also for DIV/MOD by zero.
  - div0 is 0 for every op other than DIV/MOD.
- in_valid asserted while in_ready is low is ignored. There is no queueing.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, result 0, result_hi 0, v c n z 0, div0 0, counter 0.
- Latency from E0 to the out_valid cycle: 1 cycle for single-cycle ops, N+1 cycles for MUL/DIV/MOD.
- Throughput: one op per 2 cycles (single-cycle ops) or per N+2 cycles (iterative ops). in_ready is low during EXEC and DONE.
- rst_n asserted at any time, including mid-EXEC: all outputs go to their reset values immediately, without waiting for a clock edge. The partial result is discarded and no out_valid is produced.
- The first accept is possible on the first clk edge after rst_n deasserts.

## Configuration
- ALU_SEQ_MUL_EN defined: op 8 is the iterative multiplier as specified above.
- ALU_SEQ_MUL_EN undefined: the multiplier is not built, and op 8 behaves as single-cycle PASS (result = a, result_hi = 0, c = v = 0).

## Structure
- Package alu_seq_pkg holds:
  - enum alu_op_e (4-bit, values 0–9 as above, OP_PASS = 8 when MUL is disabled);
  - enum alu_state_e (IDLE, EXEC, DONE);
  - a helper function is_iter(op).
- Sub-module alu_iter_muldiv #(N) contains:
  - shared accumulator/shift registers;
  - start, mode (MUL or DIV), a, b inputs;
  - done, quotient/product_lo, remainder/product_hi, div0 outputs.
  - The top level instantiates it and owns the FSM and flag logic.

## Test plan
- N=4: ADD a=7, b=9 → result 0x0, c=1, z=1, v=0, n=0. out_valid occurs 1 cycle after accept.
- N=4: SUB a=3, b=5 → result 0xE, c=0, n=1, v=0. SUB a=8, b=1 → result 0x7, v=1, c=1.
- N=4: DIV a=13, b=4 → result 3, out_valid 5 cycles after accept, in_ready low throughout. MOD on the same operands → result 1.
- N=4: DIV a=9, b=0 → result 0xF, div0=1, v=1. MOD a=9, b=0 → result 9, div0=1.
- N=4 with ALU_SEQ_MUL_EN: MUL a=7, b=6 → result 0xA, result_hi 0x2, c=v=1. Without the macro: MUL a=7 → result 7 after 1 cycle.
- Assert rst_n low 2 cycles into a DIV, then release. Check all outputs are at reset values with no out_valid, and that an LSL a=1, b=5 accepted next returns result 0 with z=1.
